// File: rtl/bird_motion_ctrl.sv
// Flappy-bird style vertical motion controller.
// Frame-ticked gravity/flap physics with a one-hot game FSM.
module bird_motion_ctrl #(
    parameter int TICK_DIV = 1666666,
    parameter int Y_START  = 240,
    parameter int X_BIRD   = 160,
    parameter int Y_TOP    = 0,
    parameter int Y_FLOOR  = 460,
    parameter int GRAV_ACC = 1,
    parameter int FLAP_VEL = 8,
    parameter int MAX_FALL = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Ack,
    input  logic              Flap_Button,
    output logic [9:0]        YBird,
    output logic [9:0]        XBird,
    output logic signed [7:0] Vel,
    output logic [15:0]       Frames,
    output logic              Frame_Tick,
    output logic              q_I,
    output logic              q_Wait,
    output logic              q_Upd,
    output logic              q_Lost
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [8:0]  GRAV_S  = 9'(GRAV_ACC);
    localparam logic signed [8:0]  FLAP_S  = 9'(FLAP_VEL);
    localparam logic signed [8:0]  MAXF_S  = 9'(MAX_FALL);
    localparam logic signed [10:0] TOP_S   = 11'(Y_TOP);
    localparam logic signed [10:0] FLOOR_S = 11'(Y_FLOOR);

    typedef enum logic [3:0] {
        S_I    = 4'b0001,
        S_WAIT = 4'b0010,
        S_UPD  = 4'b0100,
        S_LOST = 4'b1000
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tick_q, tick_d, tick_inc;
    logic [9:0]         y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [15:0]        frames_q, frames_d;
    logic               pend_q, pend_d;
    logic               flap_prev_q, flap_prev_d;
    logic               flap_edge;
    logic signed [8:0]  vel_inc, nv;
    logic signed [10:0] ny;

    assign Frame_Tick = (tick_q == TICK_LAST);
    assign flap_edge  = Flap_Button & ~flap_prev_q;
    assign tick_inc   = Frame_Tick ? '0 : tick_q + CNT_W'(1);

    assign YBird  = y_q;
    assign XBird  = 10'(X_BIRD);
    assign Vel    = vel_q;
    assign Frames = frames_q;
    assign q_I    = state_q[0];
    assign q_Wait = state_q[1];
    assign q_Upd  = state_q[2];
    assign q_Lost = state_q[3];

    // Candidate velocity and row for this frame, widened so nothing wraps.
    always_comb begin
        vel_inc = $signed({vel_q[7], vel_q}) + GRAV_S;
        if (pend_q) begin
            nv = -FLAP_S;
        end else if (vel_inc > MAXF_S) begin
            nv = MAXF_S;
        end else begin
            nv = vel_inc;
        end
        ny = $signed({1'b0, y_q}) + $signed({{2{nv[8]}}, nv});
    end

    // Game sequencing and next-value selection for every register.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        y_d         = y_q;
        vel_d       = vel_q;
        frames_d    = frames_q;
        pend_d      = pend_q;
        flap_prev_d = Flap_Button;
        case (state_q)
            S_I: begin
                tick_d   = '0;
                pend_d   = 1'b0;
                y_d      = 10'(Y_START);
                vel_d    = '0;
                frames_d = '0;
                if (Start) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tick_d = tick_inc;
                pend_d = pend_q | flap_edge;
                if (Frame_Tick) begin
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                tick_d   = tick_inc;
                pend_d   = flap_edge;
                frames_d = frames_q + 16'd1;
                if (ny >= FLOOR_S) begin
                    y_d     = 10'(Y_FLOOR);
                    vel_d   = '0;
                    tick_d  = '0;
                    pend_d  = 1'b0;
                    state_d = S_LOST;
                end else if (ny <= TOP_S) begin
                    y_d     = 10'(Y_TOP);
                    vel_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    y_d     = ny[9:0];
                    vel_d   = nv[7:0];
                    state_d = S_WAIT;
                end
            end
            S_LOST: begin
                tick_d = '0;
                pend_d = 1'b0;
                if (Ack) begin
                    y_d      = 10'(Y_START);
                    vel_d    = '0;
                    frames_d = '0;
                    state_d  = S_I;
                end
            end
            default: begin
                tick_d   = '0;
                pend_d   = 1'b0;
                y_d      = 10'(Y_START);
                vel_d    = '0;
                frames_d = '0;
                state_d  = S_I;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_I;
            tick_q      <= '0;
            y_q         <= 10'(Y_START);
            vel_q       <= '0;
            frames_q    <= '0;
            pend_q      <= 1'b0;
            flap_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            frames_q    <= frames_d;
            pend_q      <= pend_d;
            flap_prev_q <= flap_prev_d;
        end
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Bench for bird_motion_ctrl with TICK_DIV=4.
// Frame-level physics model plus directed literal checks.
module tb_bird_motion_ctrl;

    localparam int TD = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic              Ack = 1'b0;
    logic              Flap_Button = 1'b0;
    logic [9:0]        YBird;
    logic [9:0]        XBird;
    logic signed [7:0] Vel;
    logic [15:0]       Frames;
    logic              Frame_Tick;
    logic              q_I, q_Wait, q_Upd, q_Lost;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    typedef struct {
        int mode;
        int cnt;
        int y;
        int v;
        int frames;
        bit pend;
        bit prev;
    } model_t;

    model_t m = '{0, 0, 240, 0, 0, 1'b0, 1'b0};

    bird_motion_ctrl #(.TICK_DIV(TD)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .Flap_Button(Flap_Button), .YBird(YBird), .XBird(XBird),
        .Vel(Vel), .Frames(Frames), .Frame_Tick(Frame_Tick),
        .q_I(q_I), .q_Wait(q_Wait), .q_Upd(q_Upd), .q_Lost(q_Lost)
    );

    always #5 Clk = ~Clk;

    // mode: 0 idle, 1 waiting for tick, 2 physics update, 3 lost
    function automatic model_t step(model_t s, bit rst, bit st,
                                    bit ak, bit fl);
        model_t n;
        int nv;
        int ny;
        bit edge_s;
        bit tick;
        n = s;
        if (rst) begin
            n = '{0, 0, 240, 0, 0, 1'b0, 1'b0};
            return n;
        end
        edge_s = fl && !s.prev;
        tick   = (s.cnt == TD - 1);
        n.prev = fl;
        case (s.mode)
            0: if (st) n.mode = 1;
            1: begin
                n.pend = s.pend || edge_s;
                if (tick) n.mode = 2;
            end
            2: begin
                if (s.pend) nv = -8;
                else nv = (s.v + 1 > 10) ? 10 : s.v + 1;
                ny = s.y + nv;
                n.frames = (s.frames + 1) % 65536;
                n.pend = edge_s;
                n.mode = 1;
                if (ny >= 460) begin
                    n.y = 460; n.v = 0; n.mode = 3;
                end else if (ny <= 0) begin
                    n.y = 0; n.v = 0;
                end else begin
                    n.y = ny; n.v = nv;
                end
            end
            3: if (ak) n.mode = 0;
            default: n.mode = 0;
        endcase
        if (s.mode == 1 || s.mode == 2) n.cnt = tick ? 0 : s.cnt + 1;
        if (n.mode == 0 || n.mode == 3) begin
            n.cnt = 0; n.pend = 1'b0;
        end
        if (n.mode == 0) begin
            n.y = 240; n.v = 0; n.frames = 0;
        end
        return n;
    endfunction

    always @(posedge Clk) begin
        m <= step(m, Reset, Start, Ack, Flap_Button);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("cmp q_I", q_I, int'(m.mode == 0));
            chk("cmp q_Wait", q_Wait, int'(m.mode == 1));
            chk("cmp q_Upd", q_Upd, int'(m.mode == 2));
            chk("cmp q_Lost", q_Lost, int'(m.mode == 3));
            chk("cmp YBird", YBird, m.y);
            chk("cmp Vel", Vel, m.v);
            chk("cmp Frames", Frames, m.frames);
            chk("cmp Frame_Tick", Frame_Tick, int'(m.cnt == TD - 1));
            chk("cmp XBird", XBird, 160);
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic start_game();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_upd();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (q_Upd) begin
                got = 1'b1;
                break;
            end
        end
        chk("wait update timeout", int'(got), 1);
    endtask

    task automatic after_update(input string nm, input int ev,
                                input int ey);
        wait_upd();
        @(negedge Clk);
        chk({nm, " dut Vel"}, Vel, ev);
        chk({nm, " dut YBird"}, YBird, ey);
        chk({nm, " model Vel"}, m.v, ev);
        chk({nm, " model YBird"}, m.y, ey);
    endtask

    initial begin
        int fall_y[10];
        bit got;
        fall_y = '{241, 243, 246, 250, 255, 261, 268, 276, 285, 295};

        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        cmp_en = 1'b1;
        chk("reset q_I", q_I, 1);
        chk("reset YBird", YBird, 240);
        chk("reset Vel", Vel, 0);
        chk("reset Frames", Frames, 0);
        chk("reset Frame_Tick", Frame_Tick, 0);
        Reset = 1'b0;
        @(negedge Clk);

        start_game();
        after_update("fall1", 1, 241);
        after_update("fall2", 2, 243);
        after_update("fall3", 3, 246);
        chk("fall Frames", Frames, 3);
        chk("fall model Frames", m.frames, 3);

        do_reset();
        start_game();
        Flap_Button = 1'b1;
        @(negedge Clk);
        Flap_Button = 1'b0;
        after_update("flap1", -8, 232);

        do_reset();
        start_game();
        Flap_Button = 1'b1;
        after_update("held1", -8, 232);
        after_update("held2", -7, 225);
        after_update("held3", -6, 219);
        Flap_Button = 1'b0;

        do_reset();
        start_game();
        for (int k = 0; k < 10; k++) begin
            after_update($sformatf("floor%0d", k + 1), k + 1, fall_y[k]);
        end
        after_update("floor11", 10, 305);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (q_Lost) begin
                got = 1'b1;
                break;
            end
        end
        chk("wait lost timeout", int'(got), 1);
        chk("lost YBird", YBird, 460);
        chk("lost Vel", Vel, 0);
        chk("lost Frames", Frames, 27);
        chk("lost model Frames", m.frames, 27);
        Start = 1'b1;
        repeat (6) begin
            @(negedge Clk);
            Flap_Button = ~Flap_Button;
        end
        Start = 1'b0;
        Flap_Button = 1'b0;
        chk("lost hold q_Lost", q_Lost, 1);
        chk("lost hold YBird", YBird, 460);
        chk("lost hold Frames", Frames, 27);
        @(negedge Clk);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("ack q_I", q_I, 1);
        chk("ack YBird", YBird, 240);
        chk("ack Frames", Frames, 0);

        do_reset();
        start_game();
        Flap_Button = 1'b1;
        @(negedge Clk);
        Flap_Button = 1'b0;
        for (int i = 0; i < 33; i++) begin
            wait_upd();
            Flap_Button = 1'b1;
            @(negedge Clk);
            Flap_Button = 1'b0;
            chk("ceiling not lost", q_Lost, 0);
        end
        chk("ceiling YBird", YBird, 0);
        chk("ceiling Vel", Vel, 0);
        chk("ceiling model YBird", m.y, 0);
        chk("ceiling q_Wait", q_Wait, 1);

        do_reset();
        start_game();
        wait_upd();
        @(negedge Clk);
        wait_upd();
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst q_I", q_I, 1);
        chk("midrst YBird", YBird, 240);
        chk("midrst Vel", Vel, 0);
        chk("midrst Frames", Frames, 0);
        chk("midrst Frame_Tick", Frame_Tick, 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
